// File: rtl/timer_defs.sv
// Shared encodings and widths for the microwave countdown timer.
// Digit packing is {min_tens, min_ones, sec_tens, sec_ones}.
package timer_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int BCD_W        = 4;
    localparam int DIGITS_W     = 16;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

    function automatic logic [BCD_W-1:0] clamp_digit(
        input logic [BCD_W-1:0] d,
        input int unsigned      mx
    );
        return (d > BCD_W'(mx)) ? BCD_W'(mx) : d;
    endfunction

    function automatic logic [DIGITS_W-1:0] sanitise(
        input logic [DIGITS_W-1:0] v
    );
        return {clamp_digit(v[15:12], DIGIT_MAX),
                clamp_digit(v[11:8],  DIGIT_MAX),
                clamp_digit(v[7:4],   SEC_TENS_MAX),
                clamp_digit(v[3:0],   DIGIT_MAX)};
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MAX_VAL and raises a
// combinational borrow so digits can be chained.
module bcd_down_digit
    import timer_defs::*;
#(
    parameter int MAX_VAL = 9
) (
    input  logic             in_clock,
    input  logic             reset,
    input  logic             dec_in,
    input  logic             load_en,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] value,
    output logic             borrow_out
);

    logic [BCD_W-1:0] value_q;
    logic [BCD_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_en) begin
            value_d = load_val;
        end else if (dec_in) begin
            value_d = (value_q == '0) ? BCD_W'(MAX_VAL)
                                      : value_q - BCD_W'(1);
        end
    end

    always_ff @(posedge in_clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign borrow_out = dec_in & (value_q == '0);

endmodule

// File: rtl/countdown_timer_tick_consumer.sv
// MM:SS countdown driven by a slow tick sampled as data.
// Define TICK_SYNC_EN to pass tick_in through a 2-flop synchroniser.
module countdown_timer_tick_consumer
    import timer_defs::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic                in_clock,
    input  logic                reset,
    input  logic                tick_in,
    input  logic                load,
    input  logic [DIGITS_W-1:0] load_digits,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    output logic [DIGITS_W-1:0] digits,
    output logic                running,
    output logic                done
);

    localparam int PRESC_W = 8;

    state_e               state_q;
    logic                 tick_q;
    logic [PRESC_W-1:0]   presc_q;
    logic                 running_q;
    logic                 done_q;

    logic                 tick_s;
    logic                 tick_edge;
    logic                 wrap;
    logic                 go;
    logic                 accept_ld;
    logic                 dec;
    logic                 ld_en;
    logic [DIGITS_W-1:0]  ld_val;
    logic [DIGITS_W-1:0]  san;
    logic [DIGITS_W-1:0]  digit_v;
    logic                 reach_zero;
    logic                 b_so;
    logic                 b_st;
    logic                 b_mo;
    logic                 min_tens_borrow_unused;

`ifdef TICK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge in_clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], tick_in};
        end
    end

    assign tick_s = sync_q[1];
`else
    assign tick_s = tick_in;
`endif

    assign tick_edge = tick_s & ~tick_q;
    assign wrap      = (presc_q == PRESC_W'(TICKS_PER_SEC - 1));
    assign go        = start & (state_q == ST_READY);
    assign accept_ld = load & (state_q != ST_RUN);
    assign san       = sanitise(load_digits);

    // Ignored inputs (start outside READY) fall through to lower priorities.
    always_comb begin
        ld_en  = 1'b0;
        ld_val = san;
        dec    = 1'b0;
        if (clear) begin
            ld_en  = 1'b1;
            ld_val = '0;
        end else if (stop || go) begin
            ld_en = 1'b0;
        end else if (accept_ld) begin
            ld_en = 1'b1;
        end else if (state_q == ST_RUN && tick_edge && wrap) begin
            dec = 1'b1;
        end
    end

    assign reach_zero = dec & (digit_v == DIGITS_W'(1));

    always_ff @(posedge in_clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tick_q    <= 1'b0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tick_q <= tick_s;
            done_q <= 1'b0;
            if (clear) begin
                state_q   <= ST_IDLE;
                presc_q   <= '0;
                running_q <= 1'b0;
            end else if (stop) begin
                presc_q <= '0;
                if (state_q == ST_RUN) begin
                    state_q   <= ST_READY;
                    running_q <= 1'b0;
                end
            end else if (go) begin
                state_q   <= ST_RUN;
                presc_q   <= '0;
                running_q <= 1'b1;
            end else if (accept_ld) begin
                presc_q <= '0;
                state_q <= (san == '0) ? ST_IDLE : ST_READY;
            end else if (state_q == ST_RUN && tick_edge) begin
                presc_q <= wrap ? '0 : presc_q + PRESC_W'(1);
                if (reach_zero) begin
                    state_q   <= ST_DONE;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    bcd_down_digit #(.MAX_VAL(DIGIT_MAX)) u_sec_ones (
        .in_clock   (in_clock),
        .reset      (reset),
        .dec_in     (dec),
        .load_en    (ld_en),
        .load_val   (ld_val[3:0]),
        .value      (digit_v[3:0]),
        .borrow_out (b_so)
    );

    bcd_down_digit #(.MAX_VAL(SEC_TENS_MAX)) u_sec_tens (
        .in_clock   (in_clock),
        .reset      (reset),
        .dec_in     (b_so),
        .load_en    (ld_en),
        .load_val   (ld_val[7:4]),
        .value      (digit_v[7:4]),
        .borrow_out (b_st)
    );

    bcd_down_digit #(.MAX_VAL(DIGIT_MAX)) u_min_ones (
        .in_clock   (in_clock),
        .reset      (reset),
        .dec_in     (b_st),
        .load_en    (ld_en),
        .load_val   (ld_val[11:8]),
        .value      (digit_v[11:8]),
        .borrow_out (b_mo)
    );

    bcd_down_digit #(.MAX_VAL(DIGIT_MAX)) u_min_tens (
        .in_clock   (in_clock),
        .reset      (reset),
        .dec_in     (b_mo),
        .load_en    (ld_en),
        .load_val   (ld_val[15:12]),
        .value      (digit_v[15:12]),
        .borrow_out (min_tens_borrow_unused)
    );

    assign digits  = digit_v;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer_tick_consumer.sv
// Directed bench for countdown_timer_tick_consumer.
// Two instances share stimulus: TICKS_PER_SEC=1 and TICKS_PER_SEC=4.
module tb_countdown_timer_tick_consumer;

`ifdef TICK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_in;
    logic        load;
    logic [15:0] load_digits;
    logic        start;
    logic        stop;
    logic        clear;
    logic [15:0] digits_a;
    logic        running_a;
    logic        done_a;
    logic [15:0] digits_b;
    logic        running_b;
    logic        done_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    countdown_timer_tick_consumer #(.TICKS_PER_SEC(1)) dut_a (
        .in_clock    (clk),
        .reset       (reset),
        .tick_in     (tick_in),
        .load        (load),
        .load_digits (load_digits),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .digits      (digits_a),
        .running     (running_a),
        .done        (done_a)
    );

    countdown_timer_tick_consumer #(.TICKS_PER_SEC(4)) dut_b (
        .in_clock    (clk),
        .reset       (reset),
        .tick_in     (tick_in),
        .load        (load),
        .load_digits (load_digits),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .digits      (digits_b),
        .running     (running_b),
        .done        (done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        tick_in = 1'b1;
        repeat (LAT) step();
        tick_in = 1'b0;
        repeat (2) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        load_digits = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick_in = 1'b0;
        load = 1'b0;
        load_digits = '0;
        start = 1'b0;
        stop = 1'b0;
        clear = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        chk("rst_digits", 32'(digits_a), 32'h0000);
        chk("rst_running", 32'(running_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_state", 32'(dut_a.state_q), 0);

        // 00:02 counts to DONE with a single-cycle done pulse
        do_load(16'h0002);
        chk("ld2_digits", 32'(digits_a), 32'h0002);
        chk("ld2_state", 32'(dut_a.state_q), 1);
        do_start();
        chk("start_running", 32'(running_a), 1);
        chk("start_state", 32'(dut_a.state_q), 2);
        tick_in = 1'b1;
        repeat (LAT) step();
        chk("cnt_0001", 32'(digits_a), 32'h0001);
        chk("cnt_0001_done", 32'(done_a), 0);
        tick_in = 1'b0;
        repeat (2) step();
        tick_in = 1'b1;
        repeat (LAT) step();
        chk("cnt_0000", 32'(digits_a), 32'h0000);
        chk("done_pulse", 32'(done_a), 1);
        chk("done_state", 32'(dut_a.state_q), 3);
        chk("done_running", 32'(running_a), 0);
        tick_in = 1'b0;
        step();
        chk("done_one_cycle", 32'(done_a), 0);
        step();
        do_start();
        chk("done_start_ign", 32'(dut_a.state_q), 3);

        // full borrow chain 10:00 -> 09:59 -> 09:58
        do_clear();
        chk("clr_state", 32'(dut_a.state_q), 0);
        do_load(16'h1000);
        do_start();
        pulse();
        chk("borrow_0959", 32'(digits_a), 32'h0959);
        pulse();
        chk("borrow_0958", 32'(digits_a), 32'h0958);

        // load sanitising and zero load in IDLE
        do_clear();
        chk("clr_digits", 32'(digits_a), 32'h0000);
        do_load(16'h9A7F);
        chk("sanitise", 32'(digits_a), 32'h9959);
        chk("sanitise_state", 32'(dut_a.state_q), 1);
        do_clear();
        do_load(16'h0000);
        chk("ld0_state", 32'(dut_a.state_q), 0);
        do_start();
        chk("idle_start_state", 32'(dut_a.state_q), 0);
        chk("idle_start_run", 32'(running_a), 0);

        // stop coinciding with an edge suppresses the decrement
        do_load(16'h0100);
        do_start();
        tick_in = 1'b1;
        repeat (LAT - 1) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_digits", 32'(digits_a), 32'h0100);
        chk("stop_state", 32'(dut_a.state_q), 1);
        tick_in = 1'b0;
        repeat (2) step();
        do_start();
        chk("resume_running", 32'(running_a), 1);
        pulse();
        chk("resume_0059", 32'(digits_a), 32'h0059);

        // prescaler of 4 on instance b
        do_clear();
        do_load(16'h0005);
        do_start();
        repeat (3) pulse();
        chk("presc_3", 32'(digits_b), 32'h0005);
        pulse();
        chk("presc_4", 32'(digits_b), 32'h0004);
        repeat (4) pulse();
        chk("presc_8", 32'(digits_b), 32'h0003);

        // edge-to-digits latency
        do_clear();
        do_load(16'h0010);
        do_start();
        tick_in = 1'b1;
        repeat (LAT - 1) step();
        chk("lat_before", 32'(digits_a), 32'h0010);
        step();
        chk("lat_after", 32'(digits_a), 32'h0009);
        tick_in = 1'b0;
        repeat (2) step();

        // reset mid-RUN
        do_clear();
        do_load(16'h0530);
        do_start();
        chk("mid_run", 32'(running_a), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_digits", 32'(digits_a), 32'h0000);
        chk("mrst_running", 32'(running_a), 0);
        chk("mrst_state", 32'(dut_a.state_q), 0);
        chk("mrst_done", 32'(done_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
